pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_ctrl_hazard_detect.sv | 30 +++
 rtl/pipe_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
//   pipe_state_e   : controller FSM states (RUN, IM_WAIT, DM_WAIT)
//   REG_ADDR_W     : register-file address width
//   PERF_CNT_W     : width of the performance counters
//   PERF_CNT_MAX   : saturation value of the performance counters
//   PERF_CNT_ONE   : counter increment, sized to the counter width
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int PERF_CNT_W = 32;

    localparam logic [PERF_CNT_W-1:0] PERF_CNT_MAX = {PERF_CNT_W{1'b1}};
    localparam logic [PERF_CNT_W-1:0] PERF_CNT_ONE = {{(PERF_CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        IM_WAIT = 2'd1,
        DM_WAIT = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection (purely combinational).
// Flags when the load currently in ID/EXE writes a register that the
// instruction in IF/ID reads. Register 0 is hard-wired zero, never a hazard.
// Ports:
//   rs1_addr, rs2_addr : source registers of the IF/ID instruction
//   rd_addr            : destination register of the ID/EXE instruction
//   mem_read           : ID/EXE instruction is a load
//   load_use           : hazard present this cycle
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  mem_read,
    output logic                  load_use
);

    // Load-use comparison against both source operands
    always_comb begin
        load_use = 1'b0;
        if (mem_read && (rd_addr != {REG_ADDR_W{1'b0}}) &&
            ((rd_addr == rs1_addr) || (rd_addr == rs2_addr))) begin
            load_use = 1'b1;
        end else begin
            load_use = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: memory-stall FSM, load-use bubble insertion,
// branch flush (deferred across memory stalls) and optional perf counters.
// Optional feature: define PIPE_CTRL_PERF_EN to build the stall/flush counters;
// otherwise stall_cycles and flush_count are tied to zero.
// Ports:
//   clk, rst                       : clock (rising edge), synchronous active-high reset
//   rs1_addr, rs2_addr             : IF/ID source registers
//   IDEXE_rd_addr, IDEXE_MemRead   : ID/EXE destination and load flag
//   branch_taken                   : EXE redirect
//   im_stall, dm_stall             : instruction/data memory not ready
//   PC_write .. MEMWB_write        : pipeline-register enables
//   IFID_flush                     : load NOP into IF/ID
//   CtrlSignalFlush                : zero ID/EXE control bits
//   stall_cycles, flush_count      : performance counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [REG_ADDR_W-1:0] IDEXE_rd_addr,
    input  logic                  IDEXE_MemRead,
    input  logic                  branch_taken,
    input  logic                  im_stall,
    input  logic                  dm_stall,
    output logic                  PC_write,
    output logic                  IFID_write,
    output logic                  IDEXE_RegWrite,
    output logic                  EXEMEM_write,
    output logic                  MEMWB_write,
    output logic                  IFID_flush,
    output logic                  CtrlSignalFlush,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_count
);

    pipe_state_e state;
    pipe_state_e next_state;
    logic        pending_flush;
    logic        load_use;
    logic        stalled;

    // The stall inputs are honoured in the same cycle they are raised, so the
    // freeze decision comes straight from them; the state records which memory
    // the pipeline is currently waiting on.
    assign stalled = im_stall | dm_stall;

    hazard_detect u_hazard_detect (
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rd_addr  (IDEXE_rd_addr),
        .mem_read (IDEXE_MemRead),
        .load_use (load_use)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: data-memory stall takes priority over instruction-memory stall
    always_comb begin
        next_state = RUN;
        case (state)
            RUN, IM_WAIT, DM_WAIT: begin
                if (dm_stall) begin
                    next_state = DM_WAIT;
                end else if (im_stall) begin
                    next_state = IM_WAIT;
                end else begin
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end

    // Remember a redirect that arrived while frozen; it is applied exactly once
    // on the first cycle the pipeline moves again.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_flush <= 1'b0;
        end else if (stalled) begin
            pending_flush <= pending_flush | branch_taken;
        end else begin
            pending_flush <= 1'b0;
        end
    end

    // Pipeline enable / flush decode; priority: reset, stall, redirect, load-use
    always_comb begin
        PC_write        = 1'b0;
        IFID_write      = 1'b0;
        IDEXE_RegWrite  = 1'b0;
        EXEMEM_write    = 1'b0;
        MEMWB_write     = 1'b0;
        IFID_flush      = 1'b0;
        CtrlSignalFlush = 1'b1;
        if (rst) begin
            CtrlSignalFlush = 1'b1;
        end else if (stalled) begin
            // Everything frozen; squash ID/EXE controls once a redirect is known
            CtrlSignalFlush = branch_taken | pending_flush;
        end else if (branch_taken || pending_flush) begin
            PC_write        = 1'b1;
            IFID_write      = 1'b1;
            IDEXE_RegWrite  = 1'b1;
            EXEMEM_write    = 1'b1;
            MEMWB_write     = 1'b1;
            IFID_flush      = 1'b1;
            CtrlSignalFlush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, push a bubble into ID/EXE
            IDEXE_RegWrite  = 1'b1;
            EXEMEM_write    = 1'b1;
            MEMWB_write     = 1'b1;
            CtrlSignalFlush = 1'b1;
        end else begin
            PC_write        = 1'b1;
            IFID_write      = 1'b1;
            IDEXE_RegWrite  = 1'b1;
            EXEMEM_write    = 1'b1;
            MEMWB_write     = 1'b1;
            CtrlSignalFlush = 1'b0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= {PERF_CNT_W{1'b0}};
        end else if (!PC_write && (stall_cycles != PERF_CNT_MAX)) begin
            stall_cycles <= stall_cycles + PERF_CNT_ONE;
        end else begin
            stall_cycles <= stall_cycles;
        end
    end

    // Saturating count of cycles in which IF/ID is flushed
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_count <= {PERF_CNT_W{1'b0}};
        end else if (IFID_flush && (flush_count != PERF_CNT_MAX)) begin
            flush_count <= flush_count + PERF_CNT_ONE;
        end else begin
            flush_count <= flush_count;
        end
    end
`else
    assign stall_cycles = {PERF_CNT_W{1'b0}};
    assign flush_count  = {PERF_CNT_W{1'b0}};
`endif

endmodule
